db_filter_lt4: RTL and testbench

- Pipelined deblocking edge filter for normal-strength edges (bS 1..3), H.264 luma and chroma.
- Consumes one line of samples across an edge per beat, together with bS, indexA, alpha and beta.
- Looks up tC0 from the shared clip ROM and returns the filtered sample line.
- Sits in the db datapath between the bS/threshold calculator and the pixel write-back buffer.

---
 rtl/db_filter_lt4_pkg.sv | 75 +++++++
 rtl/rom_clip.sv | 56 +++++
 rtl/db_filter_lt4.sv | 145 ++++++++++++++
 tb/tb_db_filter_lt4.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_filter_lt4_pkg.sv
// Shared types, widths and clip helpers for the normal-strength (bS 1..3) deblocking filter.
package db_filter_lt4_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned TC_W    = 5;
    localparam int unsigned BS_W    = 3;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned ALPHA_W = 8;
    localparam int unsigned BETA_W  = 5;
    localparam int unsigned TCX_W   = 6;
    localparam int unsigned RAW_W   = 11;
    localparam int unsigned SW      = PIX_W + 4;
    localparam int unsigned ROM_AW  = BS_W + IDX_W;

    localparam logic [BS_W-1:0] BS_NONE   = BS_W'(0);
    localparam logic [BS_W-1:0] BS_STRONG = BS_W'(4);

    typedef logic [PIX_W-1:0]     pix_t;
    typedef logic signed [SW-1:0] sw_t;

    typedef struct packed {
        pix_t p2;
        pix_t p1;
        pix_t p0;
        pix_t q0;
        pix_t q1;
        pix_t q2;
    } line_t;

    typedef struct packed {
        logic               chroma;
        logic [BS_W-1:0]    bs;
        logic [ALPHA_W-1:0] alpha;
        logic [BETA_W-1:0]  beta;
        logic [TC_W-1:0]    tc0;
        line_t              px;
    } s1_t;

    typedef struct packed {
        logic                    chroma;
        logic                    flag;
        logic                    ap;
        logic                    aq;
        logic [TCX_W-1:0]        tc;
        logic [TC_W-1:0]         tc0;
        logic signed [RAW_W-1:0] raw;
        line_t                   px;
    } s2_t;

    typedef struct packed {
        logic  filt;
        line_t px;
    } s3_t;

    function automatic pix_t abs_diff(input pix_t a, input pix_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic sw_t to_sw(input pix_t p);
        return $signed(SW'(p));
    endfunction

    function automatic sw_t clip3(input sw_t lo, input sw_t hi, input sw_t x);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic pix_t clip1(input sw_t x);
        if (x < sw_t'(0)) return '0;
        if (x > to_sw({PIX_W{1'b1}})) return '1;
        return PIX_W'(x);
    endfunction

endpackage

// File: rtl/rom_clip.sv
// tC0 lookup indexed by {bS, indexA}; bS outside 1..3 or indexA above 51 returns 0.
module rom_clip
    import db_filter_lt4_pkg::*;
(
    input  logic [ROM_AW-1:0] addr_i,
    output logic [TC_W-1:0]   tc0_o
);

    logic [BS_W-1:0]     bs;
    logic [IDX_W-1:0]    idx;
    logic [3*TC_W-1:0]   row;

    assign bs  = addr_i[ROM_AW-1 -: BS_W];
    assign idx = addr_i[IDX_W-1:0];

    // Row packs {tC0(bS=3), tC0(bS=2), tC0(bS=1)}.
    always_comb begin
        row = '0;
        case (idx)
            6'd17, 6'd18, 6'd19, 6'd20: row = {5'd1,  5'd0,  5'd0};
            6'd21, 6'd22:               row = {5'd1,  5'd1,  5'd0};
            6'd23, 6'd24, 6'd25, 6'd26: row = {5'd1,  5'd1,  5'd1};
            6'd27, 6'd28, 6'd29, 6'd30: row = {5'd2,  5'd1,  5'd1};
            6'd31, 6'd32:               row = {5'd3,  5'd2,  5'd1};
            6'd33:                      row = {5'd3,  5'd2,  5'd2};
            6'd34:                      row = {5'd4,  5'd2,  5'd2};
            6'd35, 6'd36:               row = {5'd4,  5'd3,  5'd2};
            6'd37:                      row = {5'd5,  5'd3,  5'd3};
            6'd38, 6'd39:               row = {5'd6,  5'd4,  5'd3};
            6'd40:                      row = {5'd7,  5'd5,  5'd4};
            6'd41:                      row = {5'd8,  5'd5,  5'd4};
            6'd42:                      row = {5'd9,  5'd6,  5'd4};
            6'd43:                      row = {5'd10, 5'd7,  5'd5};
            6'd44:                      row = {5'd11, 5'd8,  5'd6};
            6'd45:                      row = {5'd13, 5'd8,  5'd6};
            6'd46:                      row = {5'd14, 5'd10, 5'd7};
            6'd47:                      row = {5'd16, 5'd11, 5'd8};
            6'd48:                      row = {5'd18, 5'd12, 5'd9};
            6'd49:                      row = {5'd20, 5'd13, 5'd10};
            6'd50:                      row = {5'd23, 5'd15, 5'd11};
            6'd51:                      row = {5'd25, 5'd17, 5'd13};
            default:                    row = '0;
        endcase
    end

    always_comb begin
        tc0_o = '0;
        case (bs)
            3'd1:    tc0_o = row[TC_W-1:0];
            3'd2:    tc0_o = row[2*TC_W-1:TC_W];
            3'd3:    tc0_o = row[3*TC_W-1:2*TC_W];
            default: tc0_o = '0;
        endcase
    end

endmodule

// File: rtl/db_filter_lt4.sv
// Three-stage normal-strength edge filter: S1 registers inputs and tC0, S2 decides and
// derives tC/raw delta, S3 applies the clipped corrections. A stall freezes every stage.
module db_filter_lt4
    import db_filter_lt4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               chroma_i,
    input  logic [BS_W-1:0]    bs_i,
    input  logic [IDX_W-1:0]   index_a_i,
    input  logic [ALPHA_W-1:0] alpha_i,
    input  logic [BETA_W-1:0]  beta_i,
    input  logic [PIX_W-1:0]   p2_i,
    input  logic [PIX_W-1:0]   p1_i,
    input  logic [PIX_W-1:0]   p0_i,
    input  logic [PIX_W-1:0]   q0_i,
    input  logic [PIX_W-1:0]   q1_i,
    input  logic [PIX_W-1:0]   q2_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PIX_W-1:0]   p2_o,
    output logic [PIX_W-1:0]   p1_o,
    output logic [PIX_W-1:0]   p0_o,
    output logic [PIX_W-1:0]   q0_o,
    output logic [PIX_W-1:0]   q1_o,
    output logic [PIX_W-1:0]   q2_o,
    output logic               filt_o
);

    logic            advance;
    logic [TC_W-1:0] rom_tc0;
    logic            v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q, s2_calc;
    s3_t             s3_d, s3_q, s3_calc;
    sw_t             raw_full, raw_s, tc_s, tc0_s, delta, avg, dp1, dq1;

    rom_clip u_rom_clip (
        .addr_i ({bs_i, index_a_i}),
        .tc0_o  (rom_tc0)
    );

    assign advance    = !(v3_q && !out_ready_i);
    assign in_ready_o = advance;

    // S2: filter decision, tC and unclipped delta
    always_comb begin
        s2_calc        = '0;
        raw_full       = '0;
        s2_calc.chroma = s1_q.chroma;
        s2_calc.tc0    = s1_q.tc0;
        s2_calc.px     = s1_q.px;
        s2_calc.flag   = (s1_q.bs != BS_NONE) && (s1_q.bs < BS_STRONG)
                       && (abs_diff(s1_q.px.p0, s1_q.px.q0) < s1_q.alpha)
                       && (abs_diff(s1_q.px.p1, s1_q.px.p0) < PIX_W'(s1_q.beta))
                       && (abs_diff(s1_q.px.q1, s1_q.px.q0) < PIX_W'(s1_q.beta));
        s2_calc.ap     = abs_diff(s1_q.px.p2, s1_q.px.p0) < PIX_W'(s1_q.beta);
        s2_calc.aq     = abs_diff(s1_q.px.q2, s1_q.px.q0) < PIX_W'(s1_q.beta);
        s2_calc.tc     = s1_q.chroma
                       ? TCX_W'(s1_q.tc0) + TCX_W'(1)
                       : TCX_W'(s1_q.tc0) + TCX_W'(s2_calc.ap) + TCX_W'(s2_calc.aq);
        raw_full       = ((to_sw(s1_q.px.q0) - to_sw(s1_q.px.p0)) <<< 2)
                       + (to_sw(s1_q.px.p1) - to_sw(s1_q.px.q1)) + sw_t'(4);
        s2_calc.raw    = RAW_W'(raw_full >>> 3);
    end

    // S3: clip delta and apply; p1/q1 corrections only for luma with a flat side
    always_comb begin
        s3_calc.px   = s2_q.px;
        s3_calc.filt = 1'b0;
        raw_s        = sw_t'($signed(s2_q.raw));
        tc_s         = $signed(SW'(s2_q.tc));
        tc0_s        = $signed(SW'(s2_q.tc0));
        delta        = clip3(-tc_s, tc_s, raw_s);
        avg          = (to_sw(s2_q.px.p0) + to_sw(s2_q.px.q0) + sw_t'(1)) >>> 1;
        dp1          = (to_sw(s2_q.px.p2) + avg - (to_sw(s2_q.px.p1) <<< 1)) >>> 1;
        dq1          = (to_sw(s2_q.px.q2) + avg - (to_sw(s2_q.px.q1) <<< 1)) >>> 1;
        if (s2_q.flag) begin
            s3_calc.filt  = 1'b1;
            s3_calc.px.p0 = clip1(to_sw(s2_q.px.p0) + delta);
            s3_calc.px.q0 = clip1(to_sw(s2_q.px.q0) - delta);
            if (!s2_q.chroma && s2_q.ap) begin
                s3_calc.px.p1 = clip1(to_sw(s2_q.px.p1) + clip3(-tc0_s, tc0_s, dp1));
            end
            if (!s2_q.chroma && s2_q.aq) begin
                s3_calc.px.q1 = clip1(to_sw(s2_q.px.q1) + clip3(-tc0_s, tc0_s, dq1));
            end
        end
    end

    // Pipeline advance: data only loads behind a valid beat, everything holds on stall
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (advance) begin
            v1_d = in_valid_i;
            v2_d = v1_q;
            v3_d = v2_q;
            if (in_valid_i) begin
                s1_d.chroma = chroma_i;
                s1_d.bs     = bs_i;
                s1_d.alpha  = alpha_i;
                s1_d.beta   = beta_i;
                s1_d.tc0    = rom_tc0;
                s1_d.px     = {p2_i, p1_i, p0_i, q0_i, q1_i, q2_i};
            end
            if (v1_q) s2_d = s2_calc;
            if (v2_q) s3_d = s3_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid_o = v3_q;
    assign p2_o        = s3_q.px.p2;
    assign p1_o        = s3_q.px.p1;
    assign p0_o        = s3_q.px.p0;
    assign q0_o        = s3_q.px.q0;
    assign q1_o        = s3_q.px.q1;
    assign q2_o        = s3_q.px.q2;
    assign filt_o      = s3_q.filt;

endmodule

// File: tb/tb_db_filter_lt4.sv
// Directed self-checking bench for db_filter_lt4.
module tb_db_filter_lt4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_i, in_ready_o, chroma_i;
    logic [2:0] bs_i;
    logic [5:0] index_a_i;
    logic [7:0] alpha_i;
    logic [4:0] beta_i;
    logic [7:0] p2_i, p1_i, p0_i, q0_i, q1_i, q2_i;
    logic       out_valid_o, out_ready_i;
    logic [7:0] p2_o, p1_o, p0_o, q0_o, q1_o, q2_o;
    logic       filt_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        chroma;
        logic [2:0]  bs;
        logic [5:0]  idx;
        logic [7:0]  alpha;
        logic [4:0]  beta;
        logic [47:0] pin;
        logic [47:0] pexp;
        logic        fexp;
    } vec_t;

    always #5 clk = ~clk;

    db_filter_lt4 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .chroma_i(chroma_i), .bs_i(bs_i), .index_a_i(index_a_i),
        .alpha_i(alpha_i), .beta_i(beta_i),
        .p2_i(p2_i), .p1_i(p1_i), .p0_i(p0_i), .q0_i(q0_i), .q1_i(q1_i), .q2_i(q2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .p2_o(p2_o), .p1_o(p1_o), .p0_o(p0_o), .q0_o(q0_o), .q1_o(q1_o), .q2_o(q2_o),
        .filt_o(filt_o)
    );

    function automatic vec_t mk(input logic chroma, input logic [2:0] bs, input logic [5:0] idx,
                                input logic [7:0] alpha, input logic [4:0] beta,
                                input logic [47:0] pin, input logic [47:0] pexp, input logic fexp);
        vec_t v;
        v.chroma = chroma; v.bs = bs; v.idx = idx; v.alpha = alpha; v.beta = beta;
        v.pin = pin; v.pexp = pexp; v.fexp = fexp;
        return v;
    endfunction

    function automatic logic [47:0] out_line();
        return {p2_o, p1_o, p0_o, q0_o, q1_o, q2_o};
    endfunction

    task automatic set_inputs(input vec_t v);
        chroma_i  = v.chroma;
        bs_i      = v.bs;
        index_a_i = v.idx;
        alpha_i   = v.alpha;
        beta_i    = v.beta;
        {p2_i, p1_i, p0_i, q0_i, q1_i, q2_i} = v.pin;
    endtask

    // Drive one beat and wait (bounded) for its result with out_ready_i high.
    task automatic send_one(input vec_t v, output logic [47:0] o, output logic f,
                            output int lat, output logic got);
        @(negedge clk);
        set_inputs(v);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            if (out_valid_o) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        o = out_line();
        f = filt_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || filt_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: out_valid=%b filt=%b required 0 0", out_valid_o, filt_o);
        end
        checks++;
        if (out_line() !== 48'h0) begin
            errors++; $display("FAIL reset_data: got %h required 0", out_line());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_chroma();
        vec_t v[3];
        logic [47:0] o; logic f, got; int lat;
        v[0] = mk(1'b1, 3'd1, 6'd51, 8'd20, 5'd4, {8'd0, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd0, 8'd100, 8'd104, 8'd106, 8'd110, 8'd0}, 1'b1);
        v[1] = mk(1'b1, 3'd1, 6'd51, 8'd20, 5'd4, {8'd0, 8'd110, 8'd110, 8'd100, 8'd100, 8'd0},
                  {8'd0, 8'd110, 8'd106, 8'd104, 8'd100, 8'd0}, 1'b1);
        v[2] = mk(1'b1, 3'd1, 6'd23, 8'd20, 5'd4, {8'd0, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd0, 8'd100, 8'd102, 8'd108, 8'd110, 8'd0}, 1'b1);
        foreach (v[i]) begin
            send_one(v[i], o, f, lat, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL chroma[%0d]_timeout: no out_valid after %0d cycles", i, lat);
            end else begin
                checks++;
                if (lat !== 3) begin errors++; $display("FAIL chroma[%0d]_latency: got %0d required 3", i, lat); end
                checks++;
                if (o !== v[i].pexp) begin errors++; $display("FAIL chroma[%0d]_pix: got %h required %h", i, o, v[i].pexp); end
                checks++;
                if (f !== v[i].fexp) begin errors++; $display("FAIL chroma[%0d]_filt: got %b required %b", i, f, v[i].fexp); end
            end
        end
    endtask

    task automatic test_luma();
        vec_t v[3];
        logic [47:0] o; logic f, got; int lat;
        v[0] = mk(1'b0, 3'd3, 6'd51, 8'd20, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd102, 8'd104, 8'd106, 8'd107, 8'd110}, 1'b1);
        v[1] = mk(1'b0, 3'd1, 6'd23, 8'd20, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd101, 8'd103, 8'd107, 8'd109, 8'd110}, 1'b1);
        v[2] = mk(1'b0, 3'd3, 6'd51, 8'd20, 5'd4, {8'd90, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd90, 8'd100, 8'd104, 8'd106, 8'd107, 8'd110}, 1'b1);
        foreach (v[i]) begin
            send_one(v[i], o, f, lat, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL luma[%0d]_timeout: no out_valid after %0d cycles", i, lat);
            end else begin
                checks++;
                if (o !== v[i].pexp) begin errors++; $display("FAIL luma[%0d]_pix: got %h required %h", i, o, v[i].pexp); end
                checks++;
                if (f !== v[i].fexp) begin errors++; $display("FAIL luma[%0d]_filt: got %b required %b", i, f, v[i].fexp); end
            end
        end
    endtask

    task automatic test_no_filter();
        vec_t v[4];
        logic [47:0] o; logic f, got; int lat;
        v[0] = mk(1'b0, 3'd0, 6'd51, 8'd20, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110}, 1'b0);
        v[1] = mk(1'b0, 3'd4, 6'd51, 8'd20, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110}, 1'b0);
        v[2] = mk(1'b0, 3'd3, 6'd51, 8'd10, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110}, 1'b0);
        v[3] = mk(1'b0, 3'd3, 6'd51, 8'd20, 5'd4, {8'd100, 8'd96, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd96, 8'd100, 8'd110, 8'd110, 8'd110}, 1'b0);
        foreach (v[i]) begin
            send_one(v[i], o, f, lat, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL nofilt[%0d]_timeout: no out_valid after %0d cycles", i, lat);
            end else begin
                checks++;
                if (o !== v[i].pexp) begin errors++; $display("FAIL nofilt[%0d]_pix: got %h required %h", i, o, v[i].pexp); end
                checks++;
                if (f !== v[i].fexp) begin errors++; $display("FAIL nofilt[%0d]_filt: got %b required %b", i, f, v[i].fexp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[8];
        int sent, got_n;
        logic hold, hold_filt;
        logic [47:0] hold_line;
        v[0] = mk(1'b1, 3'd1, 6'd51, 8'd20, 5'd4, {8'd10, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd10, 8'd100, 8'd104, 8'd106, 8'd110, 8'd0}, 1'b1);
        v[1] = mk(1'b0, 3'd3, 6'd51, 8'd20, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd110},
                  {8'd100, 8'd102, 8'd104, 8'd106, 8'd107, 8'd110}, 1'b1);
        v[2] = mk(1'b1, 3'd1, 6'd23, 8'd20, 5'd4, {8'd12, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd12, 8'd100, 8'd102, 8'd108, 8'd110, 8'd0}, 1'b1);
        v[3] = mk(1'b1, 3'd0, 6'd51, 8'd20, 5'd4, {8'd13, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd13, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0}, 1'b0);
        v[4] = mk(1'b1, 3'd1, 6'd51, 8'd20, 5'd4, {8'd14, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd14, 8'd100, 8'd104, 8'd106, 8'd110, 8'd0}, 1'b1);
        v[5] = mk(1'b0, 3'd3, 6'd51, 8'd20, 5'd4, {8'd100, 8'd100, 8'd100, 8'd110, 8'd110, 8'd111},
                  {8'd100, 8'd102, 8'd104, 8'd106, 8'd108, 8'd111}, 1'b1);
        v[6] = mk(1'b1, 3'd1, 6'd23, 8'd20, 5'd4, {8'd16, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd16, 8'd100, 8'd102, 8'd108, 8'd110, 8'd0}, 1'b1);
        v[7] = mk(1'b1, 3'd4, 6'd51, 8'd20, 5'd4, {8'd17, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
                  {8'd17, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0}, 1'b0);
        sent = 0; got_n = 0; hold = 1'b0; hold_line = '0; hold_filt = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            out_ready_i = !(c >= 4 && c <= 6);
            #1;
            if (c >= 4 && c <= 6) begin
                checks++;
                if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_stall_c%0d: out_valid=%b in_ready=%b required 1 0", c, out_valid_o, in_ready_o);
                end
            end
            if (hold) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_line() !== hold_line || filt_o !== hold_filt) begin
                    errors++; $display("FAIL b2b_hold_c%0d: got %b %h %b required 1 %h %b", c, out_valid_o, out_line(), filt_o, hold_line, hold_filt);
                end
            end
            hold = 1'b0;
            if (out_valid_o === 1'b1) begin
                if (out_ready_i) begin
                    checks++;
                    if (got_n >= 8) begin
                        errors++; $display("FAIL b2b_extra: unexpected beat %h", out_line());
                    end else if (out_line() !== v[got_n].pexp || filt_o !== v[got_n].fexp) begin
                        errors++; $display("FAIL b2b_beat%0d: got %h/%b required %h/%b", got_n, out_line(), filt_o, v[got_n].pexp, v[got_n].fexp);
                    end
                    got_n++;
                end else begin
                    hold = 1'b1; hold_line = out_line(); hold_filt = filt_o;
                end
            end
            if (sent < 8) begin
                set_inputs(v[sent]);
                in_valid_i = 1'b1;
                if (in_ready_o) sent++;
            end else begin
                in_valid_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        checks++;
        if (got_n !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d beats required 8", got_n);
        end
    endtask

    task automatic test_reset_midflight();
        vec_t v;
        int seen;
        v = mk(1'b1, 3'd1, 6'd51, 8'd20, 5'd4, {8'd0, 8'd100, 8'd100, 8'd110, 8'd110, 8'd0},
               {8'd0, 8'd100, 8'd104, 8'd106, 8'd110, 8'd0}, 1'b1);
        out_ready_i = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            set_inputs(v);
            in_valid_i = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_prefill: out_valid=%b required 1", out_valid_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_line() !== 48'h0 || filt_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_immediate: got %b %h %b required 0 0 0", out_valid_o, out_line(), filt_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid_o !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rstmid_stale: out_valid seen %0d cycles required 0", seen);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_i = 1'b0; out_ready_i = 1'b1; chroma_i = 1'b0;
        bs_i = '0; index_a_i = '0; alpha_i = '0; beta_i = '0;
        p2_i = '0; p1_i = '0; p0_i = '0; q0_i = '0; q1_i = '0; q2_i = '0;
        test_reset();
        test_chroma();
        test_luma();
        test_no_filter();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
